// File: rtl/mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg: shared encodings for the F/M memory-port arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_bus_grant.sv
// ---------------------------------------------------------------------------
// mem_bus_grant: picks the next bus owner; round-robin when MEM_BUS_ARB_RR_EN
// is defined, fixed data priority otherwise.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_grant
  import mem_bus_pkg::*;
(
`ifdef MEM_BUS_ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   done_i,
  input  owner_e done_owner_i,
`endif
  input  logic   req_inst_i,
  input  logic   req_data_i,
  output owner_e grant_o
);

`ifdef MEM_BUS_ARB_RR_EN
  owner_e last_owner_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= OWN_DATA;
    end else if (done_i) begin
      last_owner_q <= done_owner_i;
    end
  end

  always_comb begin
    grant_o = OWN_DATA;
    if (req_inst_i && req_data_i) begin
      grant_o = (last_owner_q == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (req_inst_i) begin
      grant_o = OWN_INST;
    end
  end
`else
  // With no request pending the result is don't-care; DATA keeps it simple.
  assign grant_o = (req_data_i || !req_inst_i) ? OWN_DATA : OWN_INST;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter: shares one SRAM-like port between fetch and data requesters,
// one outstanding transaction. Optional macro MEM_BUS_ARB_RR_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [DATA_W/8-1:0] m_wen,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            grant;
  logic              wr_q, wr_d;
  logic              i_data_ok_q, d_data_ok_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              own_req;
  logic              resp;

  assign own_req = (owner_q == OWN_DATA) ? d_req : i_req;
  // Responses outside DATA are stale or protocol violations and are dropped.
  assign resp    = (state_q == DATA) && m_data_ok;

  mem_bus_grant u_grant (
`ifdef MEM_BUS_ARB_RR_EN
    .clk          (clk),
    .rst          (rst),
    .done_i       (resp),
    .done_owner_i (owner_q),
`endif
    .req_inst_i   (i_req),
    .req_data_i   (d_req),
    .grant_o      (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_DATA;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_size    = 2'b00;
    m_wen     = '0;
    m_addr    = '0;
    m_wdata   = '0;
    i_addr_ok = 1'b0;
    d_addr_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_req = 1'b1;
        if (owner_q == OWN_DATA) begin
          m_wr      = d_wr;
          m_size    = d_size;
          m_wen     = d_wen;
          m_addr    = d_addr;
          m_wdata   = d_wdata;
          d_addr_ok = m_addr_ok;
        end else begin
          m_size    = SZ_WORD;
          m_addr    = i_addr;
          i_addr_ok = m_addr_ok;
        end
        // An accepted address always proceeds so we stay in step downstream.
        if (m_addr_ok) begin
          state_d = DATA;
          wr_d    = (owner_q == OWN_DATA) && d_wr;
        end else if (!own_req) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (m_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_data_ok_q <= 1'b0;
      d_data_ok_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_data_ok_q <= resp && (owner_q == OWN_INST);
      d_data_ok_q <= resp && (owner_q == OWN_DATA);
      // Stores complete with a pulse only; load data is left untouched.
      if (resp && !wr_q) begin
        if (owner_q == OWN_INST) begin
          i_rdata_q <= m_rdata;
        end else begin
          d_rdata_q <= m_rdata;
        end
      end
    end
  end

  assign i_data_ok = i_data_ok_q;
  assign d_data_ok = d_data_ok_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
